counter_seq_ctrl: RTL and testbench

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_seq_ctrl.sv | 103 ++++++++++
 tb/tb_counter_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Load / run / hold / done sequencing counter with modulo up/down stepping.
// Define CNT_AUTO_RELOAD_EN to make DONE loop back to LOAD for periodic operation.
module counter_seq_ctrl #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             dir_q, dir_d;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    term_d  = term_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          q_d     = load_val;
          dir_d   = dir;
          term_d  = term_val;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Terminal match wins over pause so a paused sequence at term still finishes.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (q_q == term_q) begin
          state_d = ST_DONE;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else begin
          q_d = dir_q ? (q_q + ONE) : (q_q - ONE);
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
`ifdef CNT_AUTO_RELOAD_EN
        state_d = abort ? ST_IDLE : ST_LOAD;
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      term_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      term_q  <= term_d;
      dir_q   <= dir_d;
    end
  end

  assign q     = q_q;
  assign state = state_q;
  assign busy  = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: a per-cycle behavioural model plus
// hand-computed literal expectations for the documented example sequences.
module tb_counter_seq_ctrl;

  localparam int WIDTH = 2;
  localparam int MOD   = 1 << WIDTH;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_HOLD = 3;
  localparam int P_DONE = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             pause;
  logic             abort;
  logic             dir;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [2:0]       state;

  int n_cmp = 0;
  int n_err = 0;

  int m_phase = P_IDLE;
  int m_q     = 0;
  int m_up    = 0;
  int m_term  = 0;

  counter_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .dir      (dir),
    .load_val (load_val),
    .term_val (term_val),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model of the sequence rules: counting is plain modular arithmetic on integers.
  task automatic modelStep();
    if (rst) begin
      m_phase = P_IDLE; m_q = 0; m_up = 0; m_term = 0;
    end else if (m_phase == P_IDLE) begin
      if (start) m_phase = P_LOAD;
    end else if (m_phase == P_LOAD) begin
      if (abort) m_phase = P_IDLE;
      else begin
        m_q = int'(load_val); m_term = int'(term_val); m_up = int'(dir); m_phase = P_RUN;
      end
    end else if (m_phase == P_RUN) begin
      if (abort) m_phase = P_IDLE;
      else if (m_q == m_term) m_phase = P_DONE;
      else if (pause) m_phase = P_HOLD;
      else m_q = (m_up != 0) ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
    end else if (m_phase == P_HOLD) begin
      if (abort) m_phase = P_IDLE;
      else if (!pause) m_phase = P_RUN;
    end else begin
`ifdef CNT_AUTO_RELOAD_EN
      m_phase = abort ? P_IDLE : P_LOAD;
`else
      m_phase = P_IDLE;
`endif
    end
  endtask

  // Single compare process: model advances on each edge, outputs checked 1ns later.
  always begin
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("m_state", int'(state), m_phase);
    checkOutput("m_q", int'(q), m_q);
    checkOutput("m_busy", int'(busy),
                (m_phase == P_LOAD || m_phase == P_RUN || m_phase == P_HOLD) ? 1 : 0);
    checkOutput("m_done", int'(done), (m_phase == P_DONE) ? 1 : 0);
  end

  task automatic applyStimulus(input logic r, input logic s, input logic p, input logic a,
                               input logic d, input int lv, input int tv);
    @(negedge clk);
    rst = r; start = s; pause = p; abort = a; dir = d;
    load_val = WIDTH'(lv); term_val = WIDTH'(tv);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; dir = 1'b0;
    load_val = '0; term_val = '0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_q", int'(q), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Count down 3 -> 0.
    applyStimulus(0, 1, 0, 0, 0, 3, 0);
    checkOutput("A_load_state", int'(state), 1);
    checkOutput("A_load_busy", int'(busy), 1);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    checkOutput("A_q3", int'(q), 3);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    checkOutput("A_q2", int'(q), 2);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    checkOutput("A_q1", int'(q), 1);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    checkOutput("A_q0", int'(q), 0);
    checkOutput("A_q0_nodone", int'(done), 0);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    checkOutput("A_done", int'(done), 1);
    checkOutput("A_done_state", int'(state), 4);
    checkOutput("A_done_q", int'(q), 0);
    applyStimulus(0, 0, 0, 1, 0, 3, 0);
    checkOutput("A_idle", int'(state), 0);
    checkOutput("A_idle_done", int'(done), 0);

    // Count up 2 -> 1 through the wrap; inputs changed after LOAD are ignored.
    applyStimulus(0, 1, 0, 0, 1, 2, 1);
    applyStimulus(0, 0, 0, 0, 1, 2, 1);
    checkOutput("B_q2", int'(q), 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    checkOutput("B_q3", int'(q), 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    checkOutput("B_wrap_q0", int'(q), 0);
    checkOutput("B_wrap_state", int'(state), 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    checkOutput("B_q1", int'(q), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    checkOutput("B_done", int'(done), 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 3);

    // Pause for three edges at q=2.
    applyStimulus(0, 1, 0, 0, 1, 1, 3);
    applyStimulus(0, 0, 0, 0, 1, 1, 3);
    checkOutput("C_q1", int'(q), 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 3);
    checkOutput("C_q2", int'(q), 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 1, 1, 3);
      checkOutput("C_hold_state", int'(state), 3);
      checkOutput("C_hold_q", int'(q), 2);
    end
    applyStimulus(0, 0, 0, 0, 1, 1, 3);
    checkOutput("C_resume_state", int'(state), 2);
    checkOutput("C_resume_q", int'(q), 2);
    applyStimulus(0, 0, 0, 0, 1, 1, 3);
    checkOutput("C_q3", int'(q), 3);
    applyStimulus(0, 0, 0, 0, 1, 1, 3);
    checkOutput("C_done", int'(done), 1);
    applyStimulus(0, 0, 0, 1, 1, 1, 3);

    // Abort mid-run, restart, then reset mid-run with start held.
    applyStimulus(0, 1, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    checkOutput("D_q2", int'(q), 2);
    applyStimulus(0, 0, 0, 1, 0, 3, 0);
    checkOutput("D_abort_state", int'(state), 0);
    checkOutput("D_abort_q", int'(q), 2);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    checkOutput("D_abort_nodone", int'(done), 0);
    applyStimulus(0, 1, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    checkOutput("D_restart_q", int'(q), 3);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    checkOutput("D_q1", int'(q), 1);
    applyStimulus(1, 1, 0, 0, 0, 3, 0);
    checkOutput("D_rst_q", int'(q), 0);
    checkOutput("D_rst_state", int'(state), 0);
    checkOutput("D_rst_busy", int'(busy), 0);
    applyStimulus(1, 1, 1, 1, 0, 3, 0);
    checkOutput("D_rst_hold_state", int'(state), 0);
    applyStimulus(0, 1, 0, 0, 0, 3, 0);
    checkOutput("D_post_rst_load", int'(state), 1);
    applyStimulus(0, 0, 0, 1, 0, 3, 0);
    checkOutput("D_load_abort_state", int'(state), 0);
    checkOutput("D_load_abort_q", int'(q), 0);

    // load_val == term_val, started with abort also high in IDLE.
    applyStimulus(0, 1, 0, 1, 1, 2, 2);
    checkOutput("E_load_state", int'(state), 1);
    applyStimulus(0, 0, 0, 0, 1, 2, 2);
    checkOutput("E_q2", int'(q), 2);
    applyStimulus(0, 0, 0, 0, 1, 2, 2);
    checkOutput("E_done", int'(done), 1);
    applyStimulus(0, 0, 0, 1, 1, 2, 2);

    // Abort while held.
    applyStimulus(0, 1, 0, 0, 1, 0, 3);
    applyStimulus(0, 0, 0, 0, 1, 0, 3);
    applyStimulus(0, 0, 1, 0, 1, 0, 3);
    checkOutput("F_hold", int'(state), 3);
    applyStimulus(0, 0, 1, 1, 1, 0, 3);
    checkOutput("F_abort_state", int'(state), 0);
    checkOutput("F_abort_q", int'(q), 0);

`ifdef CNT_AUTO_RELOAD_EN
    // Periodic mode: done every five cycles until abort.
    applyStimulus(0, 1, 0, 0, 1, 0, 2);
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 2);
      checkOutput("G_q0", int'(q), 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 2);
      checkOutput("G_q1", int'(q), 1);
      applyStimulus(0, 0, 0, 0, 1, 0, 2);
      checkOutput("G_q2", int'(q), 2);
      applyStimulus(0, 0, 0, 0, 1, 0, 2);
      checkOutput("G_done", int'(done), 1);
      if (rep == 0) begin
        applyStimulus(0, 0, 0, 0, 1, 0, 2);
        checkOutput("G_reload_state", int'(state), 1);
      end
    end
    applyStimulus(0, 0, 0, 1, 1, 0, 2);
    checkOutput("G_abort_state", int'(state), 0);
`endif

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
